btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, meaning: consecutive stable synchronized cycles before a level change is accepted (5 ms at 100 MHz); legal range 1..2^24-1.
REQ-002 Parameter REPEAT_DELAY, default 50000000, meaning: held cycles from press pulse to first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 12500000, meaning: cycles between subsequent auto-repeat pulses.
REQ-004 Parameter REPEAT_MASK, default 5'b10010, meaning: per-button auto-repeat enable (btnU, btnD).
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_raw  input  5  raw pushbuttons, bit map [0]=btnC [1]=btnU [2]=btnL [3]=btnR [4]=btnD; asynchronous to clk.
REQ-008 btn_level  output  5  debounced button level, registered.
REQ-009 btn_press  output  5  one-cycle pulse per accepted press or auto-repeat, registered.
REQ-010 btn_release  output  5  one-cycle pulse per accepted release, registered.

Function
REQ-011 Each bit shall pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-012 Each bit shall own an independent debounce counter sized to hold DEBOUNCE_CYCLES-1; no sharing between bits.
REQ-013 Counter: s2 == btn_level -> counter <= 0; s2 != btn_level and counter < DEBOUNCE_CYCLES-1 -> counter+1; s2 != btn_level and counter == DEBOUNCE_CYCLES-1 -> btn_level <= s2, counter <= 0.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall restart the count and never change btn_level.
REQ-015 Latency: raw edge stable from before edge 1 -> btn_level changes at edge 2+DEBOUNCE_CYCLES.
REQ-016 btn_press[i] shall be high for exactly the first cycle btn_level[i] reads 1; btn_release[i] for exactly the first cycle btn_level[i] reads 0 after a 1.
REQ-017 btn_press and btn_release for one bit shall never be high in the same cycle.
REQ-018 Simultaneous events on multiple bits shall produce simultaneous, independent pulses; no priority or masking.
REQ-019 Auto-repeat per bit (when compiled in and REPEAT_MASK[i]=1): states IDLE -> DELAY on press pulse; DELAY -> REPEAT after REPEAT_DELAY held cycles with a press pulse; REPEAT emits a press pulse every REPEAT_PERIOD cycles; any state -> IDLE when btn_level[i] falls.
REQ-020 Repeat counter shall saturate-free wrap only by reload; release in the same cycle a repeat pulse is due shall suppress that pulse and emit btn_release only.

Reset
REQ-021 While reset is high: s1, s2, btn_level, btn_press, btn_release, all debounce and repeat counters = 0; repeat FSMs = IDLE.
REQ-022 Reset asserted mid-count or mid-repeat shall discard progress; no pulse shall be emitted during or because of reset.
REQ-023 A button held through reset deassertion shall be treated as a fresh press: btn_level rises, btn_press pulses, at edge 2+DEBOUNCE_CYCLES after deassertion.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN: defined -> REQ-019/020 logic built, repeat pulses per REPEAT_MASK.
REQ-025 BTN_AUTOREPEAT_EN undefined -> no repeat counters or FSMs synthesized; btn_press pulses exactly once per accepted press regardless of REPEAT_MASK.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 btn_raw[2] 0->1 before edge 1, held -> btn_level[2]=1 and btn_press[2]=1 at edge 6 only; btn_press[2]=0 at edge 7.
REQ-027 btn_raw[0] high for 3 cycles then low -> btn_level, btn_press, btn_release stay 0 throughout.
REQ-028 btn_raw=5'b00101 simultaneously, held -> btn_press=5'b00101 in one cycle; release both -> btn_release=5'b00101 one cycle, 6 edges after release.
REQ-029 BTN_AUTOREPEAT_EN defined, btn_raw[1] held 30 cycles -> press pulses at edge 6, 16, 19, 22, 25, 28...; btn_raw[3] held same -> single pulse; undefined -> btn_raw[1] single pulse.
REQ-030 btn_raw[4] held, reset pulsed at edge 4 (mid-count) -> no pulse; btn_press[4] at edge 2+4 after reset deassertion.

Source files
------------

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Five-button conditioner. Two-flop synchronizer, per-bit
//            debounce, registered level/press/release outputs.
//            Optional per-bit auto-repeat of press pulses, built only when
//            the macro BTN_AUTOREPEAT_EN is defined (bits selected by
//            REPEAT_MASK).
// Revision : 1.0  initial release
// ============================================================================
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 12500000,
  parameter logic [4:0]  REPEAT_MASK     = 5'b10010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rep_state_t;
`endif

  logic [4:0] s1;
  logic [4:0] s2;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_bit
    logic [DW-1:0] db_cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          accept;
    logic          rise;
    logic          fall;
    logic          repeat_pulse;

    // A change is accepted on the DEBOUNCE_CYCLES-th consecutive mismatch.
    assign accept = (s2[i] != level_q) && (db_cnt == DB_LAST);
    assign rise   = accept & s2[i];
    assign fall   = accept & ~s2[i];

    // Debounce counter and registered level/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if (s2[i] == level_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt  <= '0;
          level_q <= s2[i];
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
        press_q   <= rise | repeat_pulse;
        release_q <= fall;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_t    state;
      rep_state_t    state_nxt;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] rcnt_nxt;
      logic          due;

      // Repeat FSM state and interval counter.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= IDLE;
          rcnt  <= '0;
        end else begin
          state <= state_nxt;
          rcnt  <= rcnt_nxt;
        end
      end

      // Next state; an accepted release wins over a due repeat pulse.
      always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        due       = 1'b0;
        case (state)
          IDLE: begin
            if (rise) begin
              state_nxt = DELAY;
              rcnt_nxt  = '0;
            end
          end
          DELAY: begin
            if (fall) begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end else if (rcnt == RD_LAST) begin
              due       = 1'b1;
              state_nxt = RPT;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end
          RPT: begin
            if (fall) begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end else if (rcnt == RP_LAST) begin
              due      = 1'b1;
              rcnt_nxt = '0;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end
          default: begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end
        endcase
      end

      assign repeat_pulse = due;
    end else begin : g_norep
      assign repeat_pulse = 1'b0;
    end
`else
    assign repeat_pulse = 1'b0;
`endif
  end

endmodule
`default_nettype wire
